// File: rtl/phase_result_averager.sv
// Block averager for per-frame phase/magnitude results: drops weak results,
// averages 2^LOG2_NAVG accepted ones with wrap-safe phase, emits one pair per block.
module phase_result_averager #(
    parameter int                   PH_WIDTH   = 32,
    parameter int                   MAG_WIDTH  = 32,
    parameter int                   LOG2_NAVG  = 4,
    parameter logic [MAG_WIDTH-1:0] MAG_THRESH = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 i_vld,
    input  logic [PH_WIDTH-1:0]  delta_ph,
    input  logic [MAG_WIDTH-1:0] mag,
    output logic [PH_WIDTH-1:0]  o_ph_avg,
    output logic [MAG_WIDTH-1:0] o_mag_avg,
    output logic [15:0]          o_rej_cnt,
    output logic                 o_vld
);

    localparam int PS_W  = PH_WIDTH + LOG2_NAVG;
    localparam int MS_W  = MAG_WIDTH + LOG2_NAVG;
    localparam int CNT_W = LOG2_NAVG + 1;
    localparam logic [CNT_W-1:0] N_BLK = {1'b1, {LOG2_NAVG{1'b0}}};

    typedef enum logic {IDLE, ACC} state_t;

    state_t                  state, state_n;
    logic [PH_WIDTH-1:0]     ref_ph, ref_n, ref_sel, diff;
    logic signed [PS_W-1:0]  ph_sum, ph_sum_n, ph_sum_add, ph_shift;
    logic [MS_W-1:0]         mag_sum, mag_sum_n, mag_sum_add, mag_shift;
    logic [CNT_W-1:0]        cnt, cnt_n, cnt_add;
    logic [15:0]             rej, rej_n, rej_out_n;
    logic [PH_WIDTH-1:0]     ph_avg_n;
    logic [MAG_WIDTH-1:0]    mag_avg_n;
    logic                    vld_n, accept, reject, done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ref_ph    <= '0;
            ph_sum    <= '0;
            mag_sum   <= '0;
            cnt       <= '0;
            rej       <= '0;
            o_ph_avg  <= '0;
            o_mag_avg <= '0;
            o_rej_cnt <= '0;
            o_vld     <= 1'b0;
        end else begin
            state     <= state_n;
            ref_ph    <= ref_n;
            ph_sum    <= ph_sum_n;
            mag_sum   <= mag_sum_n;
            cnt       <= cnt_n;
            rej       <= rej_n;
            o_ph_avg  <= ph_avg_n;
            o_mag_avg <= mag_avg_n;
            o_rej_cnt <= rej_out_n;
            o_vld     <= vld_n;
        end
    end

    always_comb begin
        accept  = i_vld && (mag >= MAG_THRESH);
        reject  = i_vld && !accept;

        // In IDLE the incoming sample becomes the reference, so its diff is zero
        // and the same adder path also covers the first sample of a block.
        ref_sel     = (state == IDLE) ? delta_ph : ref_ph;
        diff        = delta_ph - ref_sel;
        ph_sum_add  = ((state == IDLE) ? '0 : ph_sum) + {{LOG2_NAVG{diff[PH_WIDTH-1]}}, diff};
        ph_shift    = ph_sum_add >>> LOG2_NAVG;
        mag_sum_add = ((state == IDLE) ? '0 : mag_sum) + {{LOG2_NAVG{1'b0}}, mag};
        mag_shift   = mag_sum_add >> LOG2_NAVG;
        cnt_add     = (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
        done        = accept && (cnt_add == N_BLK);

        state_n   = state;
        ref_n     = ref_ph;
        ph_sum_n  = ph_sum;
        mag_sum_n = mag_sum;
        cnt_n     = cnt;
        rej_n     = rej;
        ph_avg_n  = o_ph_avg;
        mag_avg_n = o_mag_avg;
        rej_out_n = o_rej_cnt;
        vld_n     = 1'b0;

        if (clear) begin
            state_n   = IDLE;
            ref_n     = '0;
            ph_sum_n  = '0;
            mag_sum_n = '0;
            cnt_n     = '0;
            rej_n     = '0;
        end else begin
            if (reject && rej != 16'hFFFF)
                rej_n = rej + 16'd1;
            if (accept) begin
                state_n   = ACC;
                ref_n     = ref_sel;
                ph_sum_n  = ph_sum_add;
                mag_sum_n = mag_sum_add;
                cnt_n     = cnt_add;
            end
            if (done) begin
                ph_avg_n  = ref_sel + ph_shift[PH_WIDTH-1:0];
                mag_avg_n = mag_shift[MAG_WIDTH-1:0];
                rej_out_n = rej;
                vld_n     = 1'b1;
                state_n   = IDLE;
                ph_sum_n  = '0;
                mag_sum_n = '0;
                cnt_n     = '0;
                rej_n     = '0;
            end
        end
    end

endmodule

// File: tb/tb_phase_result_averager.sv
// Directed bench for phase_result_averager: N=4 instances with threshold 0 and 500.
module tb_phase_result_averager;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        i_vld = 1'b0;
    logic [31:0] delta_ph = '0;
    logic [31:0] mag = '0;

    logic [31:0] a_ph, a_mag, b_ph, b_mag;
    logic [15:0] a_rej, b_rej;
    logic        a_vld, b_vld;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    phase_result_averager #(
        .PH_WIDTH(32), .MAG_WIDTH(32), .LOG2_NAVG(2), .MAG_THRESH(32'd0)
    ) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .i_vld(i_vld),
        .delta_ph(delta_ph), .mag(mag),
        .o_ph_avg(a_ph), .o_mag_avg(a_mag), .o_rej_cnt(a_rej), .o_vld(a_vld)
    );

    phase_result_averager #(
        .PH_WIDTH(32), .MAG_WIDTH(32), .LOG2_NAVG(2), .MAG_THRESH(32'd500)
    ) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .i_vld(i_vld),
        .delta_ph(delta_ph), .mag(mag),
        .o_ph_avg(b_ph), .o_mag_avg(b_mag), .o_rej_cnt(b_rej), .o_vld(b_vld)
    );

    // Emit log of dut_a for the multi-cycle sequences
    logic [31:0] em_ph[$];
    int          em_cyc[$];
    always @(negedge clk) begin
        if (a_vld) begin
            em_ph.push_back(a_ph);
            em_cyc.push_back(cyc);
        end
    end

    typedef struct {
        bit          clr;
        bit          vld;
        logic [31:0] ph;
        logic [31:0] mg;
        bit          sel;
        bit          emit;
        logic [31:0] eph;
        logic [31:0] emag;
        logic [15:0] erej;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic add(input bit clr, input bit vld, input logic [31:0] ph, input logic [31:0] mg,
                       input bit sel, input bit emit, input logic [31:0] eph,
                       input logic [31:0] emag, input logic [15:0] erej);
        vec_t v;
        v.clr = clr; v.vld = vld; v.ph = ph; v.mg = mg; v.sel = sel;
        v.emit = emit; v.eph = eph; v.emag = emag; v.erej = erej;
        vecs.push_back(v);
    endtask

    task automatic send(input logic [31:0] ph, input logic [31:0] mg);
        @(negedge clk);
        i_vld = 1'b1; delta_ph = ph; mag = mg;
        @(posedge clk);
        #1;
        i_vld = 1'b0;
    endtask

    task automatic check_stream(input string nm, input int gap);
        chk({nm, "_count"}, em_ph.size(), 3);
        if (em_ph.size() == 3) begin
            chk({nm, "_ph0"}, em_ph[0], 32'd1);
            chk({nm, "_ph1"}, em_ph[1], 32'd5);
            chk({nm, "_ph2"}, em_ph[2], 32'd9);
            chk({nm, "_gap01"}, em_cyc[1] - em_cyc[0], gap);
            chk({nm, "_gap12"}, em_cyc[2] - em_cyc[1], gap);
        end
    endtask

    initial begin
        // Basic average
        add(0,1,32'd100,32'd1000,0,0,0,0,0);
        add(0,1,32'd102,32'd1004,0,0,0,0,0);
        add(0,1,32'd104,32'd1008,0,0,0,0,0);
        add(0,1,32'd106,32'd1012,0,1,32'd103,32'd1006,0);
        // Wrap across +/-pi
        add(0,1,32'h7FFFFFF0,32'd10,0,0,0,0,0);
        add(0,1,32'h80000010,32'd10,0,0,0,0,0);
        add(0,1,32'h7FFFFFF0,32'd10,0,0,0,0,0);
        add(0,1,32'h80000010,32'd10,0,1,32'h80000000,32'd10,0);
        // Wrap across zero
        add(0,1,32'hFFFFFFF8,32'd20,0,0,0,0,0);
        add(0,1,32'h00000008,32'd20,0,0,0,0,0);
        add(0,1,32'hFFFFFFF8,32'd20,0,0,0,0,0);
        add(0,1,32'h00000008,32'd20,0,1,32'h00000000,32'd20,0);
        // Negative floor
        add(0,1,32'hFFFFFFF8,32'd1,0,0,0,0,0);
        add(0,1,32'hFFFFFFF8,32'd1,0,0,0,0,0);
        add(0,1,32'hFFFFFFF7,32'd1,0,0,0,0,0);
        add(0,1,32'hFFFFFFF7,32'd2,0,1,32'hFFFFFFF7,32'd1,0);
        // Clear drops dut_b's pending rejections before the threshold block
        add(1,0,0,0,1,0,0,0,0);
        add(0,1,32'd10,32'd600,1,0,0,0,0);
        add(0,1,32'd10,32'd499,1,0,0,0,0);
        add(0,1,32'd10,32'd600,1,0,0,0,0);
        add(0,1,32'd10,32'd499,1,0,0,0,0);
        add(0,1,32'd10,32'd600,1,0,0,0,0);
        add(0,1,32'd10,32'd600,1,1,32'd10,32'd600,16'd2);
        add(0,1,32'd12,32'd500,1,0,0,0,0);
        add(0,1,32'd12,32'd500,1,0,0,0,0);
        add(0,1,32'd12,32'd500,1,0,0,0,0);
        add(0,1,32'd12,32'd500,1,1,32'd12,32'd500,16'd0);
        // Clear mid-block, coincident with a strobe
        add(1,0,0,0,0,0,0,0,0);
        add(0,1,32'd7,32'd1000,0,0,0,0,0);
        add(0,1,32'd7,32'd1000,0,0,0,0,0);
        add(0,1,32'd7,32'd1000,0,0,0,0,0);
        add(1,1,32'd7,32'd1000,0,0,0,0,0);
        add(0,1,32'd50,32'd1000,0,0,0,0,0);
        add(0,1,32'd50,32'd1000,0,0,0,0,0);
        add(0,1,32'd50,32'd1000,0,0,0,0,0);
        add(0,1,32'd50,32'd1000,0,1,32'd50,32'd1000,0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_vld", a_vld, 0);
        chk("rst_a_ph", a_ph, 0);
        chk("rst_a_mag", a_mag, 0);
        chk("rst_a_rej", a_rej, 0);
        chk("rst_b_vld", b_vld, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            clear = vecs[i].clr; i_vld = vecs[i].vld;
            delta_ph = vecs[i].ph; mag = vecs[i].mg;
            @(posedge clk);
            #1;
            clear = 1'b0; i_vld = 1'b0;
            chk($sformatf("row%0d_vld", i), vecs[i].sel ? b_vld : a_vld, vecs[i].emit);
            if (vecs[i].emit) begin
                chk($sformatf("row%0d_ph", i), vecs[i].sel ? b_ph : a_ph, vecs[i].eph);
                chk($sformatf("row%0d_mag", i), vecs[i].sel ? b_mag : a_mag, vecs[i].emag);
                chk($sformatf("row%0d_rej", i), vecs[i].sel ? b_rej : a_rej, vecs[i].erej);
            end
        end

        // Async reset between edges mid-block
        send(32'd7, 32'd1000);
        send(32'd7, 32'd1000);
        send(32'd7, 32'd1000);
        #1 rst = 1'b1;
        #1;
        chk("arst_vld", a_vld, 0);
        chk("arst_ph", a_ph, 0);
        chk("arst_mag", a_mag, 0);
        rst = 1'b0;
        em_ph.delete(); em_cyc.delete();
        for (int i = 0; i < 4; i++) send(32'd50, 32'd1000);
        repeat (6) @(posedge clk);
        chk("arst_emit_count", em_ph.size(), 1);
        if (em_ph.size() == 1) chk("arst_emit_ph", em_ph[0], 32'd50);

        // Streaming, back-to-back
        em_ph.delete(); em_cyc.delete();
        for (int i = 0; i < 12; i++) send(i, 32'd8);
        repeat (6) @(posedge clk);
        check_stream("stream1", 4);

        // Streaming, one strobe every 9 cycles
        em_ph.delete(); em_cyc.delete();
        for (int i = 0; i < 12; i++) begin
            send(i, 32'd8);
            repeat (8) @(posedge clk);
        end
        repeat (4) @(posedge clk);
        check_stream("stream9", 36);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
